// File: rtl/rd_readout_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rd_readout_sequencer_pkg
//  Description : Shared definitions for the RD readout sequencer: RD status
//                field shift macros, state encoding and RESULT codes.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef RD_READOUT_SEQUENCER_DEFS_SVH
`define RD_READOUT_SEQUENCER_DEFS_SVH
// Bit position of buffer 0 for each 4-bit per-buffer field in RD_STATUS.
`define RD_BUF_FULL_SHIFT     0
`define RD_BUF_BUSY_SHIFT     4
`define RD_BUF_TIMEOUT_SHIFT  8
`define RD_PARITY0_SHIFT      12
`define RD_PARITY1_SHIFT      16
`endif

package rd_readout_sequencer_pkg;

   localparam int RD_BUF_FULL_SHIFT    = `RD_BUF_FULL_SHIFT;
   localparam int RD_BUF_BUSY_SHIFT    = `RD_BUF_BUSY_SHIFT;
   localparam int RD_BUF_TIMEOUT_SHIFT = `RD_BUF_TIMEOUT_SHIFT;
   localparam int RD_PARITY0_SHIFT     = `RD_PARITY0_SHIFT;
   localparam int RD_PARITY1_SHIFT     = `RD_PARITY1_SHIFT;

   // Sequencer state encoding
   localparam int                 STATE_W    = 3;
   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_CHECK   = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT    = 3'd2;
   localparam logic [STATE_W-1:0] ST_XFR     = 3'd3;
   localparam logic [STATE_W-1:0] ST_CLR_RD  = 3'd4;
   localparam logic [STATE_W-1:0] ST_CLR_WCD = 3'd5;
   localparam logic [STATE_W-1:0] ST_DONE    = 3'd6;

   // RESULT[1:0] codes
   localparam logic [1:0] RES_NONE       = 2'd0;
   localparam logic [1:0] RES_XFR        = 2'd1;
   localparam logic [1:0] RES_NOT_READY  = 2'd2;
   localparam logic [1:0] RES_RD_TIMEOUT = 2'd3;

   // Pick the bit of one per-buffer status field for the given buffer.
   function automatic logic status_bit(input logic [31:0] status,
                                       input int          shift,
                                       input logic [1:0]  buf_num);
      logic [4:0] idx;
      idx = 5'(shift) + {3'b000, buf_num};
      return status[idx];
   endfunction

endpackage

`default_nettype wire

// File: rtl/rd_ctrl_write_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : rd_ctrl_write_pulse
//  Description : Drives the RD control register write: buffer number set up
//                one cycle ahead, strobe high WRT_PULSE_LEN cycles, number
//                held two cycles after the strobe falls, then done.
//  Revision    : 1.0 - initial release
// ============================================================================

module rd_ctrl_write_pulse #(
   parameter int WRT_PULSE_LEN = 4   // must be >= 3 for the receiver's 2-flop sync
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic [1:0] buf_num,
   output logic [1:0] rd_control,
   output logic       rd_control_written,
   output logic       done
);

   // step 1: setup, steps 2..LEN+1: strobe, steps LEN+2..LEN+3: hold
   localparam int LAST_STEP = WRT_PULSE_LEN + 3;
   localparam int STEP_W    = $clog2(LAST_STEP + 1);

   logic              active;
   logic [STEP_W-1:0] step;
   logic [STEP_W-1:0] step_nxt;

   assign step_nxt = step + 1'b1;

   // Step through setup / strobe / hold; strobe is registered so it is glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active             <= 1'b0;
         step               <= '0;
         rd_control         <= 2'b00;
         rd_control_written <= 1'b0;
      end else if (go) begin
         active             <= 1'b1;
         step               <= STEP_W'(1);
         rd_control         <= buf_num;
         rd_control_written <= 1'b0;
      end else if (active) begin
         if (step == STEP_W'(LAST_STEP)) begin
            active             <= 1'b0;
            step               <= '0;
            rd_control         <= 2'b00;
            rd_control_written <= 1'b0;
         end else begin
            step               <= step_nxt;
            rd_control_written <= (step_nxt >= STEP_W'(2)) &&
                                  (step_nxt <= STEP_W'(WRT_PULSE_LEN + 1));
         end
      end
   end

   assign done = active && (step == STEP_W'(LAST_STEP));

endmodule

`default_nettype wire

// File: rtl/rd_readout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rd_readout_sequencer
//  Description : CLK120-domain sequencer for processor readout of one RD
//                buffer: status check, bounded busy wait, DMA request,
//                RD full-flag clear write and WCD full-flag clear pulse.
//                Optional macro RD_SEQ_STATS_EN adds the STATS counter port.
//  Revision    : 1.0 - initial release
// ============================================================================

module rd_readout_sequencer
   import rd_readout_sequencer_pkg::*;
#(
   parameter int BUSY_WAIT_MAX = 1200,
   parameter int WRT_PULSE_LEN = 4,
   parameter int XFR_TIMEOUT   = 65535
) (
   input  logic        CLK120,
   input  logic        RST,
   input  logic        START,
   input  logic [1:0]  START_BUF,
   input  logic [31:0] RD_STATUS,
   output logic [1:0]  RD_CONTROL,
   output logic        RD_CONTROL_WRITTEN,
   output logic        XFR_REQ,
   output logic [1:0]  XFR_BUF,
   input  logic        XFR_DONE,
   output logic        WCD_CLEAR,
   output logic [1:0]  WCD_CLEAR_BUF,
   output logic        BUSY,
   output logic        DONE,
   output logic [2:0]  RESULT,
   output logic [1:0]  PARITY_ERR
`ifdef RD_SEQ_STATS_EN
   ,
   output logic [31:0] STATS
`endif
);

   localparam int WAIT_W = $clog2(BUSY_WAIT_MAX + 2);
   localparam int XFR_W  = $clog2(XFR_TIMEOUT + 1);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic [1:0]         buf_q;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [XFR_W-1:0]   xfr_cnt;

   logic               start_accept;
   logic               res_load;
   logic [2:0]         res_code;
   logic               clr_go;
   logic               wr_done;

   // Status fields of the latched buffer only
   logic full_b, busy_b, tmo_b, par0_b, par1_b;
   logic wait_expired, xfr_expired;

   assign full_b = status_bit(RD_STATUS, RD_BUF_FULL_SHIFT,    buf_q);
   assign busy_b = status_bit(RD_STATUS, RD_BUF_BUSY_SHIFT,    buf_q);
   assign tmo_b  = status_bit(RD_STATUS, RD_BUF_TIMEOUT_SHIFT, buf_q);
   assign par0_b = status_bit(RD_STATUS, RD_PARITY0_SHIFT,     buf_q);
   assign par1_b = status_bit(RD_STATUS, RD_PARITY1_SHIFT,     buf_q);

   assign wait_expired = (wait_cnt >= WAIT_W'(BUSY_WAIT_MAX));
   assign xfr_expired  = (xfr_cnt == XFR_W'(XFR_TIMEOUT - 1));

   // State register
   always_ff @(posedge CLK120 or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic plus the RESULT code and clear-write launch per transition
   always_comb begin
      state_nxt    = state;
      start_accept = 1'b0;
      res_load     = 1'b0;
      res_code     = 3'b000;
      clr_go       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (START) begin
               start_accept = 1'b1;
               state_nxt    = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (tmo_b) begin
               res_load  = 1'b1;
               res_code  = {1'b0, RES_RD_TIMEOUT};
               clr_go    = 1'b1;
               state_nxt = ST_CLR_RD;
            end else if (full_b) begin
               state_nxt = ST_XFR;
            end else if (busy_b) begin
               state_nxt = ST_WAIT;
            end else begin
               res_load  = 1'b1;
               res_code  = {1'b0, RES_NOT_READY};
               state_nxt = ST_CLR_WCD;
            end
         end
         ST_WAIT: begin
            // full wins over timeout here: data that landed is still worth reading
            if (full_b) begin
               state_nxt = ST_XFR;
            end else if (tmo_b) begin
               res_load  = 1'b1;
               res_code  = {1'b0, RES_RD_TIMEOUT};
               clr_go    = 1'b1;
               state_nxt = ST_CLR_RD;
            end else if (wait_expired || !busy_b) begin
               res_load  = 1'b1;
               res_code  = {1'b0, RES_NOT_READY};
               state_nxt = ST_CLR_WCD;
            end
         end
         ST_XFR: begin
            if (XFR_DONE) begin
               res_load  = 1'b1;
               res_code  = {1'b0, RES_XFR};
               clr_go    = 1'b1;
               state_nxt = ST_CLR_RD;
            end else if (xfr_expired) begin
               res_load  = 1'b1;
               res_code  = {1'b1, RES_XFR};
               clr_go    = 1'b1;
               state_nxt = ST_CLR_RD;
            end
         end
         ST_CLR_RD: begin
            if (wr_done) state_nxt = ST_CLR_WCD;
         end
         ST_CLR_WCD: state_nxt = ST_DONE;
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      XFR_REQ       = (state == ST_XFR);
      XFR_BUF       = (state == ST_XFR)     ? buf_q : 2'b00;
      WCD_CLEAR     = (state == ST_CLR_WCD);
      WCD_CLEAR_BUF = (state == ST_CLR_WCD) ? buf_q : 2'b00;
      BUSY          = (state != ST_IDLE);
      DONE          = (state == ST_DONE);
   end

   // Buffer latch, wait/transfer counters, RESULT and parity capture
   always_ff @(posedge CLK120 or posedge RST) begin
      if (RST) begin
         buf_q      <= 2'b00;
         wait_cnt   <= '0;
         xfr_cnt    <= '0;
         RESULT     <= 3'b000;
         PARITY_ERR <= 2'b00;
      end else begin
         if (start_accept) begin
            buf_q      <= START_BUF;
            RESULT     <= 3'b000;
            PARITY_ERR <= 2'b00;
         end
         if (res_load) RESULT <= res_code;
         if (state_nxt == ST_WAIT)
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : WAIT_W'(1);
         if (state_nxt == ST_XFR) begin
            if (state == ST_XFR) begin
               xfr_cnt <= xfr_cnt + 1'b1;
            end else begin
               xfr_cnt    <= '0;
               PARITY_ERR <= {par1_b, par0_b};
            end
         end
      end
   end

   rd_ctrl_write_pulse #(
      .WRT_PULSE_LEN (WRT_PULSE_LEN)
   ) u_ctrl_write (
      .clk                (CLK120),
      .rst                (RST),
      .go                 (clr_go),
      .buf_num            (buf_q),
      .rd_control         (RD_CONTROL),
      .rd_control_written (RD_CONTROL_WRITTEN),
      .done               (wr_done)
   );

`ifdef RD_SEQ_STATS_EN
   logic [11:0] cnt_xfr;
   logic [9:0]  cnt_skip;
   logic [9:0]  cnt_tmo;

   // Saturating per-outcome counters, bumped once per sequence at its end
   always_ff @(posedge CLK120 or posedge RST) begin
      if (RST) begin
         cnt_xfr  <= '0;
         cnt_skip <= '0;
         cnt_tmo  <= '0;
      end else if (state == ST_DONE) begin
         case (RESULT[1:0])
            RES_XFR:        if (~&cnt_xfr)  cnt_xfr  <= cnt_xfr  + 1'b1;
            RES_NOT_READY:  if (~&cnt_skip) cnt_skip <= cnt_skip + 1'b1;
            RES_RD_TIMEOUT: if (~&cnt_tmo)  cnt_tmo  <= cnt_tmo  + 1'b1;
            default: ;
         endcase
      end
   end

   assign STATS = {cnt_xfr, cnt_skip, cnt_tmo};
`endif

endmodule

`default_nettype wire

// File: tb/tb_rd_readout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rd_readout_sequencer
//  Description : Self-checking bench for rd_readout_sequencer with directed
//                and randomized sequences against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_rd_readout_sequencer;
   import rd_readout_sequencer_pkg::*;

   localparam int BWM = 1200;
   localparam int WPL = 4;
   localparam int XTO = 100;

   logic        CLK120 = 1'b0;
   logic        RST    = 1'b1;
   logic        START  = 1'b0;
   logic [1:0]  START_BUF = 2'b00;
   logic [31:0] RD_STATUS = '0;
   logic        XFR_DONE  = 1'b0;
   logic [1:0]  RD_CONTROL;
   logic        RD_CONTROL_WRITTEN;
   logic        XFR_REQ;
   logic [1:0]  XFR_BUF;
   logic        WCD_CLEAR;
   logic [1:0]  WCD_CLEAR_BUF;
   logic        BUSY;
   logic        DONE;
   logic [2:0]  RESULT;
   logic [1:0]  PARITY_ERR;
`ifdef RD_SEQ_STATS_EN
   logic [31:0] STATS;
`endif

   always #4 CLK120 = ~CLK120;

   rd_readout_sequencer #(
      .BUSY_WAIT_MAX (BWM),
      .WRT_PULSE_LEN (WPL),
      .XFR_TIMEOUT   (XTO)
   ) dut (
      .CLK120             (CLK120),
      .RST                (RST),
      .START              (START),
      .START_BUF          (START_BUF),
      .RD_STATUS          (RD_STATUS),
      .RD_CONTROL         (RD_CONTROL),
      .RD_CONTROL_WRITTEN (RD_CONTROL_WRITTEN),
      .XFR_REQ            (XFR_REQ),
      .XFR_BUF            (XFR_BUF),
      .XFR_DONE           (XFR_DONE),
      .WCD_CLEAR          (WCD_CLEAR),
      .WCD_CLEAR_BUF      (WCD_CLEAR_BUF),
      .BUSY               (BUSY),
      .DONE               (DONE),
      .RESULT             (RESULT),
      .PARITY_ERR         (PARITY_ERR)
`ifdef RD_SEQ_STATS_EN
      ,
      .STATS              (STATS)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fld(input int shift, input logic [1:0] b);
      return 32'd1 << (shift + int'(b));
   endfunction

   function automatic bit sbit(input logic [31:0] s, input int shift, input logic [1:0] b);
      return s[shift + int'(b)];
   endfunction

   function automatic logic [31:0] bufmask(input logic [1:0] b);
      return fld(RD_BUF_FULL_SHIFT, b) | fld(RD_BUF_BUSY_SHIFT, b) |
             fld(RD_BUF_TIMEOUT_SHIFT, b) | fld(RD_PARITY0_SHIFT, b) |
             fld(RD_PARITY1_SHIFT, b);
   endfunction

   function automatic logic [15:0] all_outs();
      return {RD_CONTROL, RD_CONTROL_WRITTEN, XFR_REQ, XFR_BUF, WCD_CLEAR,
              WCD_CLEAR_BUF, BUSY, DONE, RESULT, PARITY_ERR};
   endfunction

   // One full sequence. full_at >= 0: full[b] is driven low until cycle full_at.
   // done_dly > 0: XFR_DONE pulsed done_dly cycles after XFR_REQ rises; 0: withheld.
   task automatic run_seq(input string name, input logic [1:0] b, input logic [31:0] st,
                          input int full_at, input int done_dly, input bit stray);
      bit          to_b, full_b, busy_b, exp_xfr, exp_strobe, long_wait, fin;
      int          exp_rise, k, rise, req_n, bufbad, stb_first, stb_n, rdc_bad;
      int          wcd_at, wcd_n, done_at, done_n, busy_gap;
      logic [1:0]  wcd_buf, exp_par, par_at1;
      logic [2:0]  exp_res, res_at1;
      logic [31:0] m, live;
      logic [1:0]  rdc_hist [0:4095];
      logic        fin_busy;
      logic [2:0]  fin_res;
      logic [1:0]  fin_par;

      // ---- reference model ----
      to_b   = sbit(st, RD_BUF_TIMEOUT_SHIFT, b);
      full_b = sbit(st, RD_BUF_FULL_SHIFT, b) && (full_at < 0);
      busy_b = sbit(st, RD_BUF_BUSY_SHIFT, b);
      exp_xfr = 0; exp_strobe = 0; long_wait = 0; exp_rise = -1; exp_res = 3'b010;
      if (to_b) begin
         exp_res = 3'b011; exp_strobe = 1;
      end else if (full_b) begin
         exp_xfr = 1; exp_rise = 2;
      end else if (busy_b && full_at >= 0) begin
         exp_xfr = 1; exp_rise = full_at + 1;
      end else if (busy_b) begin
         long_wait = 1;
      end
      if (exp_xfr) begin
         exp_strobe = 1;
         exp_res    = (done_dly > 0) ? 3'b001 : 3'b101;
      end
      exp_par = exp_xfr ? {sbit(st, RD_PARITY1_SHIFT, b), sbit(st, RD_PARITY0_SHIFT, b)} : 2'b00;

      // ---- stimulus and observation ----
      m = bufmask(b);
      rise = -1; req_n = 0; bufbad = 0; stb_first = -1; stb_n = 0; rdc_bad = 0;
      wcd_at = -1; wcd_n = 0; wcd_buf = 2'b00; done_at = -1; done_n = 0; busy_gap = 0;
      fin = 0; res_at1 = 3'b111; par_at1 = 2'b11;
      fin_busy = 1'b1; fin_res = 3'b000; fin_par = 2'b00;

      @(posedge CLK120); #1;
      k = 0;
      START = 1'b1; START_BUF = b; XFR_DONE = 1'b0;
      live = (st & m) | ($urandom & ~m);
      if (full_at >= 0) live[RD_BUF_FULL_SHIFT + int'(b)] = 1'b0;
      RD_STATUS = live;

      while (!fin && k < 4000) begin
         @(negedge CLK120);
         rdc_hist[k] = RD_CONTROL;
         if (k == 1) begin res_at1 = RESULT; par_at1 = PARITY_ERR; end
         if (XFR_REQ) begin
            if (rise < 0) rise = k;
            req_n++;
            if (XFR_BUF !== b) bufbad++;
         end
         if (RD_CONTROL_WRITTEN) begin
            if (stb_first < 0) stb_first = k;
            stb_n++;
            if (RD_CONTROL !== b) rdc_bad++;
         end
         if (WCD_CLEAR) begin wcd_n++; wcd_at = k; wcd_buf = WCD_CLEAR_BUF; end
         if (k >= 1 && done_n == 0 && !BUSY) busy_gap++;
         if (DONE) begin done_n++; done_at = k; end
         if (done_at >= 0 && k == done_at + 1) begin
            fin = 1; fin_busy = BUSY; fin_res = RESULT; fin_par = PARITY_ERR;
         end
         if (!fin) begin
            @(posedge CLK120); #1;
            k++;
            START     = stray && (k == 5 || (wcd_at >= 0 && k == wcd_at + 1));
            START_BUF = 2'($urandom);
            XFR_DONE  = (k == 1) ||
                        (rise >= 0 && done_dly > 0 && k == rise + done_dly) ||
                        (stb_first >= 0 && k == stb_first + 1);
            live = (st & m) | ($urandom & ~m);
            if (full_at >= 0) live[RD_BUF_FULL_SHIFT + int'(b)] = (k >= full_at);
            RD_STATUS = live;
         end
      end
      START = 1'b0; XFR_DONE = 1'b0;

      // ---- comparisons ----
      check({name, "/finished"}, 32'(fin), 32'd1);
      check({name, "/res_cleared"}, {27'd0, res_at1, par_at1}, 32'd0);
      check({name, "/result"}, 32'(fin_res), 32'(exp_res));
      check({name, "/parity"}, 32'(fin_par), 32'(exp_par));
      check({name, "/req_cycles"}, 32'(req_n),
            exp_xfr ? ((done_dly > 0) ? 32'(done_dly + 1) : 32'(XTO)) : 32'd0);
      if (exp_xfr) check({name, "/req_latency"}, 32'(rise), 32'(exp_rise));
      check({name, "/xfr_buf"}, 32'(bufbad), 32'd0);
      check({name, "/strobe_len"}, 32'(stb_n), exp_strobe ? 32'(WPL) : 32'd0);
      if (exp_strobe && stb_first > 0) begin
         check({name, "/rdc_setup"}, 32'(rdc_hist[stb_first - 1]), 32'(b));
         check({name, "/rdc_strobe"}, 32'(rdc_bad), 32'd0);
         check({name, "/rdc_hold"}, 32'(rdc_hist[stb_first + WPL + 1]), 32'(b));
         check({name, "/wcd_after_strobe"}, 32'(wcd_at), 32'(stb_first + WPL + 2));
         if (to_b)
            check({name, "/strobe_start"}, 32'(stb_first), 32'd3);
         else if (done_dly > 0)
            check({name, "/strobe_start"}, 32'(stb_first), 32'(rise + done_dly + 2));
         else
            check({name, "/strobe_start"}, 32'(stb_first), 32'(rise + XTO + 1));
      end else if (long_wait) begin
         check({name, "/wait_len"}, 32'(wcd_at >= BWM + 1 && wcd_at <= BWM + 3), 32'd1);
      end else begin
         check({name, "/skip_wcd"}, 32'(wcd_at), 32'd2);
      end
      check({name, "/wcd_count"}, 32'(wcd_n), 32'd1);
      check({name, "/wcd_buf"}, 32'(wcd_buf), 32'(b));
      check({name, "/done_after_wcd"}, 32'(done_at), 32'(wcd_at + 1));
      check({name, "/busy_held"}, 32'(busy_gap), 32'd0);
      check({name, "/idle_after"}, 32'(fin_busy), 32'd0);
   endtask

   // Second START during XFR is ignored, then reset lands mid-strobe.
   task automatic reset_mid_strobe();
      bit seen;
      @(posedge CLK120); #1;
      START = 1'b1; START_BUF = 2'd2; RD_STATUS = fld(RD_BUF_FULL_SHIFT, 2);
      @(posedge CLK120); #1;
      START = 1'b0;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge CLK120);
         if (XFR_REQ) seen = 1;
      end
      check("rst/req_seen", 32'(seen), 32'd1);
      @(posedge CLK120); #1;
      START = 1'b1; START_BUF = 2'd1;
      @(negedge CLK120);
      @(posedge CLK120); #1;
      START = 1'b0; XFR_DONE = 1'b1;
      @(negedge CLK120);
      check("rst/second_start_ignored", {30'd0, XFR_REQ, 1'b0} | 32'(XFR_BUF), 32'd2 | 32'd2);
      @(posedge CLK120); #1;
      XFR_DONE = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK120);
         if (RD_CONTROL_WRITTEN) seen = 1;
      end
      check("rst/strobe_seen", 32'(seen), 32'd1);
      @(negedge CLK120);
      #2 RST = 1'b1;
      #1 check("rst/async_outputs", 32'(all_outs()), 32'd0);
      repeat (3) @(posedge CLK120);
      @(negedge CLK120);
      check("rst/held_outputs", 32'(all_outs()), 32'd0);
      RST = 1'b0;
      RD_STATUS = '0;
   endtask

   initial begin
      logic [1:0]  b;
      logic [31:0] st;
      int          full_at, done_dly;

      repeat (3) @(posedge CLK120);
      @(negedge CLK120);
      check("reset/outputs", 32'(all_outs()), 32'd0);
      RST = 1'b0;
      repeat (2) @(posedge CLK120);
      @(negedge CLK120);
      check("idle/outputs", 32'(all_outs()), 32'd0);

      run_seq("full2", 2'd2, fld(RD_BUF_FULL_SHIFT, 2), -1, 3, 0);
      run_seq("busy1_then_full", 2'd1, fld(RD_BUF_BUSY_SHIFT, 1), 500, 4, 0);
      run_seq("busy0_expire", 2'd0, fld(RD_BUF_BUSY_SHIFT, 0), -1, 5, 0);
      run_seq("tmo3", 2'd3, fld(RD_BUF_TIMEOUT_SHIFT, 3) | fld(RD_BUF_FULL_SHIFT, 3), -1, 2, 0);
      reset_mid_strobe();
      run_seq("after_rst", 2'd2, fld(RD_BUF_FULL_SHIFT, 2) | fld(RD_PARITY0_SHIFT, 2), -1, 6, 1);
      run_seq("xfr_timeout", 2'd1, fld(RD_BUF_FULL_SHIFT, 1) | fld(RD_PARITY1_SHIFT, 1), -1, 0, 0);
      run_seq("not_ready", 2'd3, 32'd0, -1, 1, 1);

      for (int i = 0; i < 25; i++) begin
         b       = 2'($urandom);
         st      = $urandom;
         full_at = -1;
         if (sbit(st, RD_BUF_BUSY_SHIFT, b) && !sbit(st, RD_BUF_TIMEOUT_SHIFT, b) &&
             $urandom_range(0, 3) != 0) begin
            st      = st & ~fld(RD_BUF_FULL_SHIFT, b);
            full_at = $urandom_range(2, 900);
         end
         done_dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30);
         run_seq("rand", b, st, full_at, done_dly, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/rd_readout_sequencer.md
Name: rd_readout_sequencer

Overview:
- Sequences the processor-side readout of one RD buffer after the WCD/SSD transfer for the same buffer number has finished.
- Checks the RD interface status for that buffer and waits a bounded time if the RD transfer is still busy.
- Requests the RD-buffer DMA, then clears the RD buffer-full flag through the RD control register write path, then pulses the WCD buffer-full clear.
- Sits in the CLK120 domain between the readout controller, the RD interface status/control registers and the RD-buffer DMA engine.

Parameters:
- BUSY_WAIT_MAX, 1200, CLK120 cycles to wait for a busy RD buffer to become full (10 us).
- WRT_PULSE_LEN, 4, CLK120 cycles RD_CONTROL_WRITTEN is held high; must be ≥3 to survive the receiver's 2-flop synchroniser.
- XFR_TIMEOUT, 65535, CLK120 cycles allowed between XFR_REQ assertion and XFR_DONE.

Ports:
- CLK120  in  1  system clock, 120 MHz
- RST  in  1  asynchronous reset, active-high
- START  in  1  one-cycle pulse: WCD/SSD transfer of buffer START_BUF complete
- START_BUF  in  2  buffer number, sampled with START
- RD_STATUS  in  32  RD interface status word; uses the full, busy, timeout and parity fields via the shared shift macros
- RD_CONTROL  out  2  buffer number whose RD full flag is cleared
- RD_CONTROL_WRITTEN  out  1  write strobe; the receiver acts on its falling edge
- XFR_REQ  out  1  level request to the RD-buffer DMA
- XFR_BUF  out  2  buffer to transfer; stable while XFR_REQ is high
- XFR_DONE  in  1  one-cycle pulse from DMA: transfer complete
- WCD_CLEAR  out  1  one-cycle pulse: clear the WCD full flag for WCD_CLEAR_BUF
- WCD_CLEAR_BUF  out  2  buffer number accompanying WCD_CLEAR
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle pulse at end of sequence
- RESULT  out  3  [1:0] code: 0 none, 1 transferred, 2 skipped-not-ready, 3 skipped-RD-timeout; [2] DMA timeout
- PARITY_ERR  out  2  parity0/parity1 flags for the buffer, captured at transfer start

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-sequence aborts immediately. RD_CONTROL_WRITTEN drops with no trailing-edge write intended; the receiver may see a falling edge, which is acceptable because the buffer number is also 0.
- State machine transitions:
  - IDLE: on START, latch B=START_BUF, BUSY=1, go to CHECK. START is ignored while BUSY=1.
  - CHECK (1 cycle), evaluated in priority order:
    - timeout[B]=1 → RESULT=3, go to CLR_RD.
    - full[B]=1 → go to XFR.
    - busy[B]=1 → load the wait counter, go to WAIT.
    - otherwise → RESULT=2, go to CLR_WCD.
  - WAIT: re-evaluates the status each cycle.
    - full[B]=1 → go to XFR.
    - timeout[B]=1 → RESULT=3, go to CLR_RD.
    - counter reaches BUSY_WAIT_MAX, or busy[B]=0 with full[B]=0 → RESULT=2, go to CLR_WCD.
  - XFR:
    - On entry, capture PARITY_ERR from parity0[B]/parity1[B], set XFR_BUF=B, assert XFR_REQ.
    - XFR_DONE → drop XFR_REQ the next cycle, RESULT=1, go to CLR_RD.
    - XFR_TIMEOUT expiry → drop XFR_REQ, RESULT[2]=1, RESULT[1:0]=1, go to CLR_RD.
  - CLR_RD: RD_CONTROL=B one cycle before the strobe. RD_CONTROL_WRITTEN is high for WRT_PULSE_LEN cycles, then low. RD_CONTROL is held for 2 further cycles, then go to CLR_WCD.
  - CLR_WCD: WCD_CLEAR=1 and WCD_CLEAR_BUF=B for one cycle, then go to DONE_ST.
  - DONE_ST: DONE=1 for one cycle, BUSY=0, return to IDLE.
- START in the same cycle as DONE is ignored (BUSY is still 1).
- XFR_DONE seen outside XFR is ignored.
- Status bits are indexed by latched B, never by the live START_BUF.
- RESULT and PARITY_ERR hold until the next START, then clear to 0.
- Latency, fully-ready case: START → XFR_REQ in 2 cycles. XFR_DONE → WCD_CLEAR in WRT_PULSE_LEN+4 cycles.

Optional Feature:
- Macro RD_SEQ_STATS_EN.
- When defined: output port STATS (32 bits) = {transferred[11:0], skipped[9:0], rd_timeout[9:0]}. Each count increments once per sequence by final RESULT code, saturates at all-ones, and clears on RST.
- When undefined: no STATS port and no counters.

Decomposition:
- Shared defs header: status field shift macros (RD_BUF_FULL_SHIFT, RD_BUF_BUSY_SHIFT, RD_BUF_TIMEOUT_SHIFT, RD_PARITY0_SHIFT, RD_PARITY1_SHIFT), the state encoding localparams, and the RESULT code constants.
- One sub-module, rd_ctrl_write_pulse: generates the RD_CONTROL/RD_CONTROL_WRITTEN set-strobe-hold timing; inputs go and buffer number, output done.

Test Plan:
- full[2]=1, START_BUF=2 → XFR_REQ 2 cycles later with XFR_BUF=2. XFR_DONE → RD_CONTROL=2 with a 4-cycle strobe, then WCD_CLEAR_BUF=2 and RESULT=1.
- busy[1]=1; full[1] set 500 cycles later → single XFR_REQ with no early skip, RESULT=1.
- busy[0] held 1 for more than 1200 cycles → no XFR_REQ, no RD_CONTROL_WRITTEN, WCD_CLEAR after wait, RESULT=2.
- timeout[3]=1 → no XFR_REQ, RD_CONTROL=3 strobe issued, RESULT=3.
- Second START during XFR, then RST asserted mid-strobe → second START ignored; after reset all outputs 0, and the next START runs a full sequence normally.
- XFR_DONE withheld (XFR_TIMEOUT=100) → XFR_REQ drops at 100 cycles, RESULT=3'b101, clear sequence still completes.
